// File: rtl/alu_operand_loader_pkg.sv
// Shared definitions for the operand loader and the ALU it feeds:
// opcode encodings, loader state encodings and common widths.
package alu_operand_loader_pkg;

   localparam int unsigned OPCODE_WIDTH = 4;
   localparam int unsigned CNT_WIDTH    = 5;

   typedef enum logic [1:0] {
      LOAD_A    = 2'd0,
      LOAD_B    = 2'd1,
      LOAD_OP   = 2'd2,
      WAIT_DONE = 2'd3
   } state_e;

   typedef enum logic [OPCODE_WIDTH-1:0] {
      OP_SRL = 4'b0010,
      OP_SRA = 4'b0011,
      OP_NOR = 4'b0111,
      OP_ADD = 4'b1000,
      OP_SUB = 4'b1010,
      OP_AND = 4'b1100,
      OP_OR  = 4'b1101,
      OP_XOR = 4'b1110
   } opcode_e;

   // True for any opcode the ALU implements.
   function automatic logic is_valid_opcode(input logic [OPCODE_WIDTH-1:0] op);
      case (op)
         OP_SRL, OP_SRA, OP_NOR, OP_ADD,
         OP_SUB, OP_AND, OP_OR,  OP_XOR: return 1'b1;
         default:                        return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/alu_operand_loader_edge_detector.sv
// Synchronises the asynchronous enter level and emits a one-cycle press
// pulse per rising edge.
module edge_detector (
   input  logic clk,
   input  logic rst_n,
   input  logic level,
   output logic press
);

   logic sync1;
   logic sync2;
   logic sync3;
   logic primed;
   logic armed;

   // Two synchroniser flops, one history flop, and arming flags. A press is
   // only honoured once a genuine low level has been captured after reset, so
   // a button held across reset release cannot fake a rising edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1  <= 1'b0;
         sync2  <= 1'b0;
         sync3  <= 1'b0;
         primed <= 1'b0;
         armed  <= 1'b0;
      end else begin
         sync1  <= level;
         sync2  <= sync1;
         sync3  <= sync2;
         primed <= 1'b1;
         if (primed && !sync1) begin
            armed <= 1'b1;
         end
      end
   end

   assign press = sync2 & ~sync3 & armed;

endmodule

// File: rtl/alu_operand_loader.sv
// Collects operand A, operand B and an opcode from the switches on three
// enter presses, launches the ALU and waits (bounded) for completion.
module alu_operand_loader #(
   parameter int unsigned DATA_WIDTH     = 8,
   parameter int unsigned OPCODE_WIDTH   = alu_operand_loader_pkg::OPCODE_WIDTH,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic                    i_clock,
   input  logic                    i_reset,
   input  logic [DATA_WIDTH-1:0]   i_switches,
   input  logic                    i_enter,
   input  logic                    i_done,
   output logic [DATA_WIDTH-1:0]   o_operandA,
   output logic [DATA_WIDTH-1:0]   o_operandB,
   output logic [OPCODE_WIDTH-1:0] o_opcode,
   output logic                    o_start,
   output logic [1:0]              o_state,
   output logic                    o_error,
   output logic                    o_timeout
);

   import alu_operand_loader_pkg::*;

   localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

   state_e                  state_q;
   state_e                  state_d;
   logic [DATA_WIDTH-1:0]   opa_q;
   logic [DATA_WIDTH-1:0]   opa_d;
   logic [DATA_WIDTH-1:0]   opb_q;
   logic [DATA_WIDTH-1:0]   opb_d;
   logic [OPCODE_WIDTH-1:0] opc_q;
   logic [OPCODE_WIDTH-1:0] opc_d;
   logic                    start_q;
   logic                    start_d;
   logic                    error_q;
   logic                    error_d;
   logic                    timeout_q;
   logic                    timeout_d;
   logic [CNT_WIDTH-1:0]    cnt_q;
   logic [CNT_WIDTH-1:0]    cnt_d;
   logic                    press;
   logic [OPCODE_WIDTH-1:0] op_in;

   assign op_in = i_switches[OPCODE_WIDTH-1:0];

   edge_detector u_edge_detector (
      .clk   (i_clock),
      .rst_n (i_reset),
      .level (i_enter),
      .press (press)
   );

   // State, latched operands, pulse outputs and dwell counter.
   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         state_q   <= LOAD_A;
         opa_q     <= '0;
         opb_q     <= '0;
         opc_q     <= '0;
         start_q   <= 1'b0;
         error_q   <= 1'b0;
         timeout_q <= 1'b0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         opa_q     <= opa_d;
         opb_q     <= opb_d;
         opc_q     <= opc_d;
         start_q   <= start_d;
         error_q   <= error_d;
         timeout_q <= timeout_d;
         cnt_q     <= cnt_d;
      end
   end

   // Next-state and next-output decode; the counter stays clear outside
   // WAIT_DONE so it always starts from zero on entry.
   always_comb begin
      state_d   = state_q;
      opa_d     = opa_q;
      opb_d     = opb_q;
      opc_d     = opc_q;
      start_d   = 1'b0;
      error_d   = 1'b0;
      timeout_d = 1'b0;
      cnt_d     = '0;
      case (state_q)
         LOAD_A: begin
            if (press) begin
               opa_d   = i_switches;
               state_d = LOAD_B;
            end
         end
         LOAD_B: begin
            if (press) begin
               opb_d   = i_switches;
               state_d = LOAD_OP;
            end
         end
         LOAD_OP: begin
            if (press) begin
               if (is_valid_opcode(op_in)) begin
                  opc_d   = op_in;
                  start_d = 1'b1;
                  state_d = WAIT_DONE;
               end else begin
                  error_d = 1'b1;
               end
            end
         end
         WAIT_DONE: begin
            if (i_done) begin
               state_d = LOAD_A;
            end else if (cnt_q == TIMEOUT_LAST) begin
               timeout_d = 1'b1;
               state_d   = LOAD_A;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = LOAD_A;
         end
      endcase
   end

   assign o_operandA = opa_q;
   assign o_operandB = opb_q;
   assign o_opcode   = opc_q;
   assign o_start    = start_q;
   assign o_error    = error_q;
   assign o_timeout  = timeout_q;
   assign o_state    = state_q;

   // Pulse outputs never overlap and each lasts a single cycle.
   a_pulses_exclusive : assert property (@(posedge i_clock) disable iff (!i_reset)
      $onehot0({start_q, error_q, timeout_q}));
   a_start_single     : assert property (@(posedge i_clock) disable iff (!i_reset)
      start_q |=> !start_q);
   a_timeout_single   : assert property (@(posedge i_clock) disable iff (!i_reset)
      timeout_q |=> !timeout_q);

endmodule

// File: tb/tb_alu_operand_loader.sv
// Self-checking bench for alu_operand_loader: a small reference model
// predicts each start/error/timeout pulse into a queue, and a monitor pops
// and compares whenever the DUT raises a pulse.
module tb_alu_operand_loader;

   localparam int unsigned DW = 8;
   localparam int unsigned OW = 4;
   localparam int unsigned TO = 16;

   localparam logic [2:0] K_START = 3'b100;
   localparam logic [2:0] K_ERR   = 3'b010;
   localparam logic [2:0] K_TMO   = 3'b001;

   typedef struct packed {
      logic [2:0]    kind;
      logic [DW-1:0] a;
      logic [DW-1:0] b;
      logic [OW-1:0] op;
      logic [1:0]    st;
   } ev_t;

   logic          clk   = 1'b0;
   logic          rst_n = 1'b0;
   logic [DW-1:0] sw    = '0;
   logic          enter = 1'b0;
   logic          done  = 1'b0;
   logic [DW-1:0] opa;
   logic [DW-1:0] opb;
   logic [OW-1:0] opc;
   logic          start;
   logic          err;
   logic          tmo;
   logic [1:0]    st;

   int n_checks = 0;
   int n_fail   = 0;
   ev_t exp_q[$];

   logic [DW-1:0] m_a     = '0;
   logic [DW-1:0] m_b     = '0;
   logic [OW-1:0] m_op    = '0;
   logic [1:0]    m_state = 2'd0;
   logic [OW-1:0] valid_ops [8] = '{4'b1000, 4'b1010, 4'b1100, 4'b1101,
                                    4'b1110, 4'b0011, 4'b0010, 4'b0111};

   alu_operand_loader #(
      .DATA_WIDTH     (DW),
      .OPCODE_WIDTH   (OW),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .i_clock    (clk),
      .i_reset    (rst_n),
      .i_switches (sw),
      .i_enter    (enter),
      .i_done     (done),
      .o_operandA (opa),
      .o_operandB (opb),
      .o_opcode   (opc),
      .o_start    (start),
      .o_state    (st),
      .o_error    (err),
      .o_timeout  (tmo)
   );

   always #5 clk = ~clk;

   // Scoreboard: every pulse seen must match the oldest prediction.
   always @(negedge clk) begin
      ev_t got;
      ev_t want;
      if (start || err || tmo) begin
         got = '{kind: {start, err, tmo}, a: opa, b: opb, op: opc, st: st};
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_pulse: got %h, expected no pulse", got);
         end else begin
            want = exp_q.pop_front();
            if (got !== want) begin
               n_fail++;
               $display("FAIL pulse_event: got %h, expected %h", got, want);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic op_ok(input logic [OW-1:0] op);
      for (int i = 0; i < 8; i++) begin
         if (valid_ops[i] == op) return 1'b1;
      end
      return 1'b0;
   endfunction

   function automatic void model_press(input logic [DW-1:0] v);
      logic [OW-1:0] op;
      op = v[OW-1:0];
      case (m_state)
         2'd0: begin m_a = v; m_state = 2'd1; end
         2'd1: begin m_b = v; m_state = 2'd2; end
         2'd2: begin
            if (op_ok(op)) begin
               m_op    = op;
               m_state = 2'd3;
               exp_q.push_back('{kind: K_START, a: m_a, b: m_b, op: m_op, st: 2'd3});
            end else begin
               exp_q.push_back('{kind: K_ERR, a: m_a, b: m_b, op: m_op, st: 2'd2});
            end
         end
         default: ;
      endcase
   endfunction

   function automatic void model_reset();
      m_a = '0; m_b = '0; m_op = '0; m_state = 2'd0;
   endfunction

   task automatic step(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic press(input logic [DW-1:0] v, input int hold);
      sw = v;
      enter = 1'b1;
      model_press(v);
      step(hold);
      enter = 1'b0;
      step(4);
   endtask

   task automatic press_until_start(input logic [DW-1:0] v, output bit ok);
      int n;
      n = 0;
      sw = v;
      enter = 1'b1;
      model_press(v);
      while (!start && n < 10) begin step(1); n++; end
      enter = 1'b0;
      ok = start;
   endtask

   task automatic done_pulse();
      done = 1'b1;
      step(1);
      done = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      step(2);
      n_checks++;
      if ({opa, opb, opc, start, err, tmo, st} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %h, expected 0", {opa, opb, opc, start, err, tmo, st});
      end
      rst_n = 1'b1;
      step(3);
      n_checks++;
      if (st !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d, expected 0", st); end
      model_reset();
   endtask

   task automatic test_press_latency();
      sw = 8'hA7;
      enter = 1'b1;
      model_press(8'hA7);
      step(2);
      n_checks++;
      if (st !== 2'd0) begin n_fail++; $display("FAIL latency_early: got state %0d, expected 0", st); end
      step(1);
      n_checks++;
      if ({st, opa} !== {2'd1, 8'hA7}) begin
         n_fail++;
         $display("FAIL latency_third_edge: got %h, expected %h", {st, opa}, {2'd1, 8'hA7});
      end
      enter = 1'b0;
      step(4);
      press(8'h01, 4);
      press(8'h08, 4);
      done_pulse();
      m_state = 2'd0;
   endtask

   task automatic test_load_start();
      bit ok;
      press(8'd4, 4);
      press(8'd5, 4);
      press_until_start(8'h08, ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL load_start_seen: got no o_start, expected o_start"); end
      n_checks++;
      if ({opa, opb, opc, st} !== {8'd4, 8'd5, 4'b1000, 2'd3}) begin
         n_fail++;
         $display("FAIL load_values: got %h, expected %h", {opa, opb, opc, st}, {8'd4, 8'd5, 4'b1000, 2'd3});
      end
      step(1);
      n_checks++;
      if (start !== 1'b0) begin n_fail++; $display("FAIL start_width: got %b, expected 0", start); end
      press(8'h77, 4);
      n_checks++;
      if ({opa, st} !== {8'd4, 2'd3}) begin
         n_fail++;
         $display("FAIL press_in_wait: got %h, expected %h", {opa, st}, {8'd4, 2'd3});
      end
      done_pulse();
      m_state = 2'd0;
      n_checks++;
      if (st !== 2'd0) begin n_fail++; $display("FAIL done_return: got %0d, expected 0", st); end
   endtask

   task automatic test_done_hold();
      bit ok;
      press(8'hF6, 4);
      press(8'h80, 4);
      press_until_start(8'h0A, ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL sub_start_seen: got no o_start, expected o_start"); end
      step(3);
      n_checks++;
      if (st !== 2'd3) begin n_fail++; $display("FAIL sub_waiting: got %0d, expected 3", st); end
      done_pulse();
      m_state = 2'd0;
      n_checks++;
      if ({st, opa, opb, opc} !== {2'd0, 8'hF6, 8'h80, 4'b1010}) begin
         n_fail++;
         $display("FAIL done_next: got %h, expected %h", {st, opa, opb, opc}, {2'd0, 8'hF6, 8'h80, 4'b1010});
      end
      step(5);
      n_checks++;
      if ({st, opa, opb, opc} !== {2'd0, 8'hF6, 8'h80, 4'b1010}) begin
         n_fail++;
         $display("FAIL operands_held: got %h, expected %h", {st, opa, opb, opc}, {2'd0, 8'hF6, 8'h80, 4'b1010});
      end
   endtask

   task automatic test_invalid_opcode();
      bit ok;
      press(8'h11, 4);
      press(8'h22, 4);
      press(8'h05, 4);
      n_checks++;
      if ({st, opc, err} !== {2'd2, m_op, 1'b0}) begin
         n_fail++;
         $display("FAIL error_stay: got %h, expected %h", {st, opc, err}, {2'd2, m_op, 1'b0});
      end
      press_until_start(8'h0C, ok);
      n_checks++;
      if (!ok || opc !== 4'b1100) begin
         n_fail++;
         $display("FAIL retry_start: got start=%b op=%b, expected start=1 op=1100", ok, opc);
      end
      done_pulse();
      m_state = 2'd0;
   endtask

   task automatic test_timeout();
      bit ok;
      int n;
      press(8'h01, 4);
      press(8'h02, 4);
      press_until_start(8'h0E, ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL tmo_start_seen: got no o_start, expected o_start"); end
      exp_q.push_back('{kind: K_TMO, a: m_a, b: m_b, op: m_op, st: 2'd0});
      m_state = 2'd0;
      n = 0;
      while (!tmo && n < 40) begin step(1); n++; end
      n_checks++;
      if (n != TO) begin n_fail++; $display("FAIL timeout_cycles: got %0d, expected %0d", n, TO); end
      n_checks++;
      if (st !== 2'd0) begin n_fail++; $display("FAIL timeout_state: got %0d, expected 0", st); end
      step(2);
   endtask

   task automatic test_done_at_timeout();
      bit ok;
      press(8'h03, 4);
      press(8'h04, 4);
      press_until_start(8'h07, ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL nor_start_seen: got no o_start, expected o_start"); end
      step(TO - 1);
      n_checks++;
      if (st !== 2'd3) begin n_fail++; $display("FAIL last_wait_cycle: got %0d, expected 3", st); end
      done_pulse();
      m_state = 2'd0;
      n_checks++;
      if ({st, tmo} !== {2'd0, 1'b0}) begin
         n_fail++;
         $display("FAIL done_beats_timeout: got %b, expected %b", {st, tmo}, {2'd0, 1'b0});
      end
      step(4);
   endtask

   task automatic test_hold_enter();
      press(8'h3C, 20);
      n_checks++;
      if ({st, opa, opb} !== {2'd1, 8'h3C, m_b}) begin
         n_fail++;
         $display("FAIL held_enter: got %h, expected %h", {st, opa, opb}, {2'd1, 8'h3C, m_b});
      end
      done_pulse();
      n_checks++;
      if (st !== 2'd1) begin n_fail++; $display("FAIL done_ignored: got %0d, expected 1", st); end
   endtask

   task automatic test_reset_mid();
      bit ok;
      press(8'h5A, 4);
      n_checks++;
      if (st !== 2'd2) begin n_fail++; $display("FAIL reach_load_op: got %0d, expected 2", st); end
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({opa, opb, opc, start, err, tmo, st} !== '0) begin
         n_fail++;
         $display("FAIL reset_in_load_op: got %h, expected 0", {opa, opb, opc, start, err, tmo, st});
      end
      model_reset();
      step(2);
      rst_n = 1'b1;
      step(20);
      n_checks++;
      if (st !== 2'd0) begin n_fail++; $display("FAIL after_reset_op: got %0d, expected 0", st); end

      press(8'h01, 4);
      press(8'h02, 4);
      press_until_start(8'h0D, ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL or_start_seen: got no o_start, expected o_start"); end
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({opa, opb, opc, start, err, tmo, st} !== '0) begin
         n_fail++;
         $display("FAIL reset_in_start: got %h, expected 0", {opa, opb, opc, start, err, tmo, st});
      end
      model_reset();
      step(2);
      enter = 1'b1;
      step(1);
      rst_n = 1'b1;
      step(10);
      n_checks++;
      if ({st, opa} !== {2'd0, 8'h00}) begin
         n_fail++;
         $display("FAIL enter_across_reset: got %h, expected %h", {st, opa}, {2'd0, 8'h00});
      end
      enter = 1'b0;
      step(4);
      press(8'h99, 4);
      n_checks++;
      if ({st, opa} !== {2'd1, 8'h99}) begin
         n_fail++;
         $display("FAIL press_after_reset: got %h, expected %h", {st, opa}, {2'd1, 8'h99});
      end
   endtask

   initial begin
      test_reset();
      test_press_latency();
      test_load_start();
      test_done_hold();
      test_invalid_opcode();
      test_timeout();
      test_done_at_timeout();
      test_hold_enter();
      test_reset_mid();
      step(5);
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL missing_pulses: got %0d unmatched predictions, expected 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_operand_loader.md
ALU_OPERAND_LOADER -- requirements
Module: alu_operand_loader

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset; ports SHALL be named i_clock and i_reset.
REQ-002 Parameters SHALL be, one per line:
- DATA_WIDTH, 8, operand width.
- OPCODE_WIDTH, 4, opcode width.
- TIMEOUT_CYCLES, 16, maximum WAIT_DONE dwell before abort.
REQ-003 Ports SHALL be:
- i_clock, input, 1, system clock, rising edge.
- i_reset, input, 1, asynchronous active-low reset.
- i_switches, input, DATA_WIDTH, user data; low OPCODE_WIDTH bits used as opcode.
- i_enter, input, 1, asynchronous debounced enter button level.
- i_done, input, 1, ALU completion strobe.
- o_operandA, output, DATA_WIDTH, latched operand A to ALU.
- o_operandB, output, DATA_WIDTH, latched operand B to ALU.
- o_opcode, output, OPCODE_WIDTH, latched opcode to ALU.
- o_start, output, 1, one-cycle start pulse to ALU.
- o_state, output, 2, current FSM state for LEDs.
- o_error, output, 1, one-cycle pulse on rejected opcode.
- o_timeout, output, 1, one-cycle pulse on WAIT_DONE abort.

Function
REQ-004 i_enter SHALL pass a 2-flop synchroniser plus one history flop; a press event SHALL be sync2 & ~sync3, one cycle wide per rising edge of i_enter.
REQ-005 A press event SHALL take effect on the 3rd rising i_clock edge after i_enter rises; holding i_enter high SHALL produce exactly one event.
REQ-006 FSM states SHALL be LOAD_A=0, LOAD_B=1, LOAD_OP=2, WAIT_DONE=3, driven on o_state.
REQ-007 LOAD_A + press: o_operandA <= i_switches, next LOAD_B.
REQ-008 LOAD_B + press: o_operandB <= i_switches, next LOAD_OP.
REQ-009 LOAD_OP + press with valid opcode: o_opcode <= i_switches[3:0], o_start=1 for exactly the next cycle, next WAIT_DONE.
REQ-010 Valid opcodes SHALL be ADD 1000, SUB 1010, AND 1100, OR 1101, XOR 1110, SRA 0011, SRL 0010, NOR 0111.
REQ-011 LOAD_OP + press with invalid opcode: o_opcode unchanged, o_error=1 for one cycle, stay LOAD_OP.
REQ-012 WAIT_DONE: a 5-bit cycle counter SHALL clear on entry and increment each cycle.
REQ-013 WAIT_DONE + i_done=1: next LOAD_A; operands and opcode SHALL hold until overwritten.
REQ-014 WAIT_DONE with counter reaching TIMEOUT_CYCLES-1 and i_done=0: o_timeout=1 for one cycle, next LOAD_A; if i_done and timeout coincide, i_done wins and o_timeout stays 0.
REQ-015 Press events in WAIT_DONE and i_done outside WAIT_DONE SHALL be ignored.
REQ-016 All outputs SHALL be registered; o_start, o_error and o_timeout SHALL never overlap.

Reset
REQ-017 i_reset low SHALL asynchronously force state LOAD_A, o_operandA=0, o_operandB=0, o_opcode=0, o_start=0, o_error=0, o_timeout=0, sync/history flops=0, counter=0.
REQ-018 Reset mid-operation, including during an o_start pulse, SHALL abort it with no further pulse after release.
REQ-019 An i_enter held high across reset release SHALL NOT generate a press event.

Structure
REQ-020 Opcode encodings, state encodings and OPCODE_WIDTH SHALL live in a shared package used by both this block and the ALU.
REQ-021 The synchroniser/edge detector SHALL be a sub-module named edge_detector.

Verification
REQ-022 Benches SHALL cover these scenarios:
- Load A=4, B=5, op=1000 via three presses -> o_start one cycle, o_operandA=4, o_operandB=5, o_opcode=1000, o_state=3.
- Load A=0xF6, B=0x80, op=1010, i_done 3 cycles after o_start -> o_state=0 next cycle, operands held.
- op=0101 in LOAD_OP -> o_error one cycle, o_opcode unchanged, o_state=2; then op=1100 -> o_start.
- No i_done after o_start -> o_timeout after 16 cycles, o_state=0; i_done on the timeout cycle -> no o_timeout.
- i_enter held 20 cycles in LOAD_A -> only o_operandA loads, o_state=1.
- Reset asserted in LOAD_OP and in WAIT_DONE -> all outputs 0, o_state=0 immediately, no pulse after release.
